// File: rtl/compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compositor_pkg
//  Description : Shared constants and default-palette helper for the pixel
//                compositor.
//  Revision    : 1.0 - initial release
// ============================================================================
package compositor_pkg;

  // Default output pixel width (4:4:4 RGB)
  localparam int DEF_COLOR_W = 12;

  // Named colours at the default 4:4:4 width
  localparam logic [DEF_COLOR_W-1:0] BLACK = 12'h000;
  localparam logic [DEF_COLOR_W-1:0] WHITE = 12'hFFF;
  localparam logic [DEF_COLOR_W-1:0] GREEN = 12'h0F0;
  localparam logic [DEF_COLOR_W-1:0] RED   = 12'hF00;

  // Default palette entry for an index at an arbitrary colour width (<= 32).
  // Green and red are full-scale patterns in the middle and top thirds.
  function automatic logic [31:0] default_entry(input int idx, input int color_w);
    int          f;
    logic [31:0] field;
    logic [31:0] all_ones;
    f        = color_w / 3;
    field    = (32'd1 << f) - 32'd1;
    all_ones = (color_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << color_w) - 32'd1);
    case (idx)
      0:       return all_ones;
      2:       return field << f;
      3:       return field << (2 * f);
      default: return 32'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/compositor_palette.sv
`default_nettype none
// ============================================================================
//  Module      : compositor_palette
//  Description : Palette register file: synchronous write, combinational read,
//                reset to default colours. With COMPOSITOR_BLINK_EN defined it
//                also holds a per-entry blink mask written with the colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module compositor_palette
  import compositor_pkg::*;
#(
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int WORLD_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en_i,
  input  logic [WORLD_W-1:0] wr_addr_i,
  input  logic [COLOR_W-1:0] wr_data_i,
`ifdef COMPOSITOR_BLINK_EN
  input  logic               blink_wr_i,
  output logic               rd_blink_o,
`endif
  input  logic [WORLD_W-1:0] rd_addr_i,
  output logic [COLOR_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** WORLD_W;

  logic [DEPTH-1:0][COLOR_W-1:0] pal_q;
  logic [DEPTH-1:0][COLOR_W-1:0] pal_d;

  function automatic logic [COLOR_W-1:0] def_val(input int idx);
    logic [31:0] t;
    t = default_entry(idx, COLOR_W);
    return t[COLOR_W-1:0];
  endfunction

  // Next palette contents: only the addressed entry changes on a write
  always_comb begin
    pal_d = pal_q;
    if (wr_en_i) pal_d[wr_addr_i] = wr_data_i;
  end

  // Palette registers with per-index reset defaults
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= def_val(i);
    end else begin
      pal_q <= pal_d;
    end
  end

  // Read returns the pre-write value during a write cycle
  assign rd_data_o = pal_q[rd_addr_i];

`ifdef COMPOSITOR_BLINK_EN
  logic [DEPTH-1:0] mask_q;
  logic [DEPTH-1:0] mask_d;

  // Blink mask bit follows the colour write of the same entry
  always_comb begin
    mask_d = mask_q;
    if (wr_en_i) mask_d[wr_addr_i] = blink_wr_i;
  end

  // Blink mask register, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  assign rd_blink_o = mask_q[rd_addr_i];
`endif

endmodule
`default_nettype wire

// File: rtl/pixel_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_compositor
//  Description : Two-stage pixel compositor. Stage 1 registers the palette
//                lookup, layers and syncs; stage 2 registers the priority
//                overlay with blanking. Optional blink feature is enabled by
//                defining COMPOSITOR_BLINK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_compositor
  import compositor_pkg::*;
#(
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int WORLD_W      = 2,
  parameter int NUM_LAYERS   = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enableVideo,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          frame_tick,
  input  logic [WORLD_W-1:0]            worldIn,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layers_in,
  input  logic                          pal_wr_en,
  input  logic [WORLD_W-1:0]            pal_wr_addr,
  input  logic [COLOR_W-1:0]            pal_wr_data,
  input  logic                          pal_blink_wr,
  output logic [COLOR_W-1:0]            drawColor,
  output logic                          hsync_out,
  output logic                          vsync_out
);

  logic [COLOR_W-1:0] pal_rd_data;
  logic [COLOR_W-1:0] base_d;

`ifdef COMPOSITOR_BLINK_EN
  localparam int                CNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             pal_rd_blink;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             phase_q;
  logic             phase_d;

  compositor_palette #(
    .COLOR_W (COLOR_W),
    .WORLD_W (WORLD_W)
  ) u_palette (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (pal_wr_en),
    .wr_addr_i  (pal_wr_addr),
    .wr_data_i  (pal_wr_data),
    .blink_wr_i (pal_blink_wr),
    .rd_blink_o (pal_rd_blink),
    .rd_addr_i  (worldIn),
    .rd_data_o  (pal_rd_data)
  );

  // Frame counter: toggle the blink phase every BLINK_FRAMES ticks
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Masked entries go black during the off phase; layers are not affected
  assign base_d = (phase_q && pal_rd_blink) ? '0 : pal_rd_data;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink_inputs;

  compositor_palette #(
    .COLOR_W (COLOR_W),
    .WORLD_W (WORLD_W)
  ) u_palette (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (pal_wr_en),
    .wr_addr_i (pal_wr_addr),
    .wr_data_i (pal_wr_data),
    .rd_addr_i (worldIn),
    .rd_data_o (pal_rd_data)
  );

  assign unused_blink_inputs = &{1'b0, frame_tick, pal_blink_wr};
  assign base_d              = pal_rd_data;
`endif

  logic                          en_s1_q;
  logic                          hs_s1_q;
  logic                          vs_s1_q;
  logic [COLOR_W-1:0]            base_s1_q;
  logic [NUM_LAYERS*COLOR_W-1:0] layers_s1_q;
  logic [COLOR_W-1:0]            color_d;
  logic [COLOR_W-1:0]            color_q;
  logic                          hs_q;
  logic                          vs_q;

  // Stage 1: capture video enable, syncs, base colour and raw layers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_s1_q     <= 1'b0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      base_s1_q   <= '0;
      layers_s1_q <= '0;
    end else begin
      en_s1_q     <= enableVideo;
      hs_s1_q     <= hsync_in;
      vs_s1_q     <= vsync_in;
      base_s1_q   <= base_d;
      layers_s1_q <= layers_in;
    end
  end

  // Overlay: lowest-index opaque layer wins, else base; blank outside video
  always_comb begin
    color_d = base_s1_q;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layers_s1_q[k*COLOR_W +: COLOR_W] != '0) color_d = layers_s1_q[k*COLOR_W +: COLOR_W];
    end
    if (!en_s1_q) color_d = '0;
  end

  // Stage 2: registered output with syncs delayed to match
  always_ff @(posedge clk) begin
    if (reset) begin
      color_q <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      color_q <= color_d;
      hs_q    <= hs_s1_q;
      vs_q    <= vs_s1_q;
    end
  end

  assign drawColor = color_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;

endmodule
`default_nettype wire

// File: doc/pixel_compositor.md
# pixel_compositor

Pipelined, parametrised pixel compositor between the VGA timing generator and the RGB output pins. It maps each world-map code through a run-time-writable palette, overlays up to NUM_LAYERS icon layers by fixed priority, and blanks the output outside the active video region. Output is registered with a fixed two-cycle latency, matched by delaying the sync outputs.

## Interface
- COLOR_W, 12: bits per output pixel (4:4:4 RGB at default).
- WORLD_W, 2: world code width; palette depth is 2**WORLD_W.
- NUM_LAYERS, 2: icon layer count; layer 0 has highest priority.
- BLINK_FRAMES, 30: frame_tick count per blink half-period (blink build only).
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enableVideo  in  1  pixel is in the active region.
- hsync_in, vsync_in  in  1 each  sync from the timing generator.
- frame_tick  in  1  one-cycle pulse per frame.
- worldIn  in  WORLD_W  world-map code for this pixel.
- layers_in  in  NUM_LAYERS*COLOR_W  layer k at bits [k*COLOR_W +: COLOR_W]; all-zero means transparent.
- pal_wr_en  in  1  palette write strobe.
- pal_wr_addr  in  WORLD_W  palette entry to write.
- pal_wr_data  in  COLOR_W  new colour.
- pal_blink_wr  in  1  with pal_wr_en: new blink-mask bit for that entry (blink build only; ignored otherwise).
- drawColor  out  COLOR_W  composited pixel.
- hsync_out, vsync_out  out  1 each  syncs delayed to match drawColor.

## Operation
- Palette: 2**WORLD_W registers. Reset values: entry 0 = all ones (white), 1 = 0 (black), 2 = 12'h0F0 (green), 3 = 12'hF00 (red), higher entries 0. For COLOR_W ≠ 12, green/red are the equivalent full-scale field patterns.
- Palette write: when pal_wr_en=1, the entry is updated at that clock edge. A stage-1 lookup in the same cycle reads the old value; the new value is used from the next cycle.
- Stage 1 registers: enableVideo, syncs, palette[worldIn] (base colour), and all layers_in.
- Stage 2 registers the output. If delayed enableVideo=0, drawColor=0. Otherwise drawColor = the lowest-index non-zero layer; if all layers are zero, the base colour.
- Pipeline is free-running with no stall or backpressure; every input cycle produces exactly one output two cycles later.

## Timing
- Latency: inputs at edge N appear on drawColor, hsync_out and vsync_out after edge N+2.
- Reset: drawColor=0, hsync_out=vsync_out=0, all pipeline registers 0, palette at default values, blink counter and phase 0.
- Reset mid-frame: output is 0 for the reset cycle and the following two cycles; afterwards normal operation with default palette.
- pal_wr_en during active video is legal; the colour change is visible from pixel N+1 at output edge N+3.
- frame_tick is ignored in the non-blink build.

## Configuration
- COMPOSITOR_BLINK_EN defined:
  - Adds a 2**WORLD_W-bit blink mask, reset 0, written with the palette entry via pal_blink_wr.
  - A frame counter counts frame_tick pulses and toggles blink_phase every BLINK_FRAMES ticks, then wraps to 0.
  - While blink_phase=1, a base colour whose entry has its mask bit set is replaced by 0 (black). Layers are unaffected.
  - Phase and mask are sampled in stage 1, so latency stays 2.
- COMPOSITOR_BLINK_EN undefined: no mask, counter or phase logic; pal_blink_wr and frame_tick are unused.

## Structure
- Shared package compositor_pkg: COLOR_W default, named colour constants (BLACK, WHITE, GREEN, RED), and a function returning the default palette entry for an index.
- One sub-module: compositor_palette, the register file with synchronous write, combinational read and reset defaults. The blink mask lives in it when enabled.

## Test plan
- Reset, then worldIn=0..3 with enableVideo=1 and layers zero -> drawColor FFF, 000, 0F0, F00, each two cycles after its input.
- Layers: layer0=0, layer1=12'h00F, worldIn=2 -> 00F; set layer0=12'h123 -> 123; both layers 0 -> 0F0.
- enableVideo=0 with layer0=12'hABC -> drawColor=0; the hsync/vsync pattern is reproduced delayed by exactly 2 cycles.
- Write entry 0 = 12'h555 while worldIn=0 is streaming -> the pixel in the write cycle shows FFF and the next pixel shows 555.
- Assert reset in mid-stream after a palette write -> output 0 for 3 cycles; entry 0 reads back as FFF.
- Blink build, BLINK_FRAMES=2: set blink bit on entry 3, worldIn=3 -> F00 for 2 frame_ticks, 000 for 2, then F00 again; entry 2 never blinks.
